// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants (also used by the ALU stage),
// memory-stage FSM states and the latched memory request record.
package pipe_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_SLL  = 6'b000101;
    localparam logic [5:0] OP_SRL  = 6'b000110;
    localparam logic [5:0] OP_SRA  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001001;
    localparam logic [5:0] OP_ORI  = 6'b001010;
    localparam logic [5:0] OP_XORI = 6'b001011;
    localparam logic [5:0] OP_LDW  = 6'b001100;
    localparam logic [5:0] OP_STW  = 6'b001101;
    localparam logic [5:0] OP_BZ   = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_JR   = 6'b010000;

    // The request record is sized for the standard 32-bit data path.
    localparam int PIPE_ADDR_W = 32;
    localparam int PIPE_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                   is_store;
        logic [PIPE_ADDR_W-1:0] addr;
        logic [PIPE_DATA_W-1:0] wdata;
        logic [4:0]             dst;
    } mem_txn_t;

    function automatic logic is_alu_op(input logic [5:0] op);
        return op <= OP_XORI;
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results to write-back and runs
// LDW/STW through a request/grant/response handshake with a load timeout.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W      = PIPE_ADDR_W,
    parameter int DATA_W      = PIPE_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [5:0]        ex_op,
    input  logic [DATA_W-1:0] ex_rd,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_sdata,
    input  logic [4:0]        ex_dst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [4:0]        wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mem_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    mem_txn_t          txn, txn_n;

    logic              ret;
    logic              ret_wen;
    logic              ret_err;
    logic [4:0]        ret_dst;
    logic [DATA_W-1:0] ret_data;

    // ex_ready is gated by rst_n so it reads 0 while reset is held.
    assign ex_ready  = rst_n && (state == IDLE);
    assign mem_req   = (state == REQ);
    assign mem_we    = txn.is_store;
    assign mem_addr  = ADDR_W'(txn.addr);
    assign mem_wdata = DATA_W'(txn.wdata);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        txn_n    = txn;
        ret      = 1'b0;
        ret_wen  = 1'b0;
        ret_err  = 1'b0;
        ret_dst  = txn.dst;
        ret_data = '0;

        unique case (state)
            IDLE: begin
                if (ex_valid) begin
                    ret_dst = ex_dst;
                    if (is_mem_op(ex_op)) begin
                        if (ex_addr[1:0] != 2'b00) begin
                            ret     = 1'b1;
                            ret_err = 1'b1;
                        end else begin
                            state_n        = REQ;
                            txn_n.is_store = (ex_op == OP_STW);
                            txn_n.addr     = PIPE_ADDR_W'(ex_addr);
                            txn_n.wdata    = PIPE_DATA_W'(ex_sdata);
                            txn_n.dst      = ex_dst;
                        end
                    end else begin
                        ret      = 1'b1;
                        ret_wen  = is_alu_op(ex_op);
                        ret_data = ex_rd;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (txn.is_store) begin
                        state_n = IDLE;
                        ret     = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = '0;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n  = IDLE;
                    ret      = 1'b1;
                    ret_wen  = 1'b1;
                    ret_data = mem_rdata;
                end else if (cnt >= CNT_LAST) begin
                    state_n = IDLE;
                    ret     = 1'b1;
                    ret_err = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            txn      <= '0;
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dst   <= '0;
            wb_data  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            txn      <= txn_n;
            wb_valid <= ret;
            wb_wen   <= ret_wen;
            wb_err   <= ret_err;
            wb_dst   <= ret_dst;
            wb_data  <= ret_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random ops, with the bench
// acting as data memory and predicting each retire from the op's rules.
module tb_mem_stage;
    import pipe_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [5:0]  ex_op = '0;
    logic [31:0] ex_rd = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_sdata = '0;
    logic [4:0]  ex_dst = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_dst(ex_dst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_data(wb_data),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_wen"}, 32'(wb_wen), 32'd0);
        check({tag, "_wb_err"}, 32'(wb_err), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_ex_ready"}, 32'(ex_ready), 32'd0);
    endtask

    // Issue one op with the bench playing memory: grant on the (g+1)-th request
    // cycle, rvalid after r empty WAIT cycles (r >= T means never). Called
    // between a negedge and the following posedge; returns at the retire negedge.
    task automatic do_op(input logic [5:0] op, input logic [31:0] rd, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] dst, input int g,
                         input int r, input logic [31:0] rdata);
        bit is_mem, amem, ld, st, hit, in_wait, done;
        bit exp_wen, exp_err;
        int exp_lat, t;
        logic [31:0] exp_data;

        is_mem  = (op == OP_LDW) || (op == OP_STW);
        amem    = is_mem && (addr[1:0] == 2'b00);
        ld      = amem && (op == OP_LDW);
        st      = amem && (op == OP_STW);
        exp_wen = (op <= OP_XORI) || (ld && r < T);
        exp_err = is_mem && (!amem || (ld && r >= T));
        if (st)          exp_lat = g + 2;
        else if (ld)     exp_lat = (r < T) ? g + 3 + r : g + 2 + T;
        else             exp_lat = 1;
        if (op <= OP_XORI) exp_data = rd;
        else if (ld && r < T) exp_data = rdata;
        else exp_data = 32'd0;

        check("ready_pre", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_op = op; ex_rd = rd; ex_addr = addr; ex_sdata = sdata; ex_dst = dst;
        mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        done = 0;
        t = 0;
        while (!done && t < 64) begin
            @(negedge clk);
            t++;
            ex_valid = 1'b0; ex_op = 6'($urandom); ex_rd = $urandom; ex_addr = $urandom;
            check("mem_req", 32'(mem_req), 32'(amem && t <= g + 1));
            if (amem && t <= g + 1) begin
                check("mem_we", 32'(mem_we), 32'(st));
                check("mem_addr", mem_addr, addr);
                if (st) check("mem_wdata", mem_wdata, sdata);
            end
            if (wb_valid) begin
                done = 1;
                check("latency", 32'(t), 32'(exp_lat));
                check("wb_wen", 32'(wb_wen), 32'(exp_wen));
                check("wb_err", 32'(wb_err), 32'(exp_err));
                if (exp_wen || exp_err) check("wb_data", wb_data, exp_data);
                if (exp_wen) check("wb_dst", 32'(wb_dst), 32'(dst));
                check("ready_ret", 32'(ex_ready), 32'd1);
            end else begin
                check("ready_busy", 32'(ex_ready), 32'(!amem));
            end
            hit     = ld && (r < T) && (t == g + 2 + r);
            in_wait = ld && (t >= g + 2) && (t < g + 2 + ((r < T) ? r : T));
            if (amem && t == g + 1) mem_gnt = 1'b1;
            else if (amem && t <= g) mem_gnt = 1'b0;
            else mem_gnt = 1'($urandom);
            if (hit) mem_rvalid = 1'b1;
            else if (in_wait) mem_rvalid = 1'b0;
            else mem_rvalid = 1'($urandom);
            mem_rdata = hit ? rdata : $urandom;
        end
        check("retire_seen", 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [5:0]  op;
        int          sel;

        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(ex_ready), 32'd1);

        $display("[TB] ALU passthrough");
        do_op(OP_ADD, 32'h7, 32'h0, 32'h0, 5'd5, 0, 0, 32'h0);
        do_op(OP_XORI, 32'hCAFE_0001, 32'h3, 32'h0, 5'd17, 0, 0, 32'h0);
        $display("[TB] load, zero-wait memory");
        do_op(OP_LDW, 32'h0, 32'h100, 32'h0, 5'd3, 0, 0, 32'hDEAD_BEEF);
        $display("[TB] store, grant after 3 request cycles");
        do_op(OP_STW, 32'h0, 32'h40, 32'h1234, 5'd9, 2, 0, 32'h0);
        $display("[TB] misaligned load and branch");
        do_op(OP_LDW, 32'h0, 32'h102, 32'h0, 5'd4, 0, 0, 32'h0);
        do_op(OP_BEQ, 32'h55, 32'h0, 32'h0, 5'd6, 0, 0, 32'h0);
        $display("[TB] load timeout and stray rvalid");
        do_op(OP_LDW, 32'h0, 32'h200, 32'h0, 5'd8, 1, T + 3, 32'h0);
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("stray_wb_valid", 32'(wb_valid), 32'd0);
        check("stray_ready", 32'(ex_ready), 32'd1);
        check("stray_mem_req", 32'(mem_req), 32'd0);

        $display("[TB] reset during REQ");
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        ex_valid = 1'b1; ex_op = OP_STW; ex_addr = 32'h80; ex_sdata = 32'h77; ex_dst = 5'd2;
        @(negedge clk);
        ex_valid = 1'b0;
        check("rq_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_req");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset during WAIT");
        ex_valid = 1'b1; ex_op = OP_LDW; ex_addr = 32'h300; ex_dst = 5'd12;
        @(negedge clk);
        ex_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("wt_mem_req", 32'(mem_req), 32'd0);
        check("wt_ready", 32'(ex_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_rvalid_wb", 32'(wb_valid), 32'd0);
        check("late_rvalid_ready", 32'(ex_ready), 32'd1);
        mem_rvalid = 1'b0;
        do_op(OP_SUB, 32'h0000_ABCD, 32'h0, 32'h0, 5'd21, 0, 0, 32'h0);

        $display("[TB] random ops");
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (sel <= 2)      op = 6'($urandom_range(0, 11));
            else if (sel <= 4) op = OP_LDW;
            else if (sel <= 6) op = OP_STW;
            else if (sel == 7) op = 6'($urandom_range(14, 16));
            else               op = 6'($urandom_range(17, 63));
            do_op(op, $urandom, a, $urandom, 5'($urandom), $urandom_range(0, 4),
                  $urandom_range(0, T + 1), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
